// File: rtl/pool_window_feeder.sv
`default_nettype none
// ==== pool_window_feeder: ping-pong two-row line buffer, re-emits each pair in 2x2 window order ====
// ==== Rev 1.0 ====
module pool_window_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int MAP_WIDTH  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic                  in_last_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  act_valid_o,
    output logic                  act_last_o,
    output logic [DATA_WIDTH-1:0] act_result_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int CW = (MAP_WIDTH > 2) ? $clog2(MAP_WIDTH) : 1;
    localparam int KW = (MAP_WIDTH > 4) ? $clog2(MAP_WIDTH / 2) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(MAP_WIDTH / 2 - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [2][2][MAP_WIDTH];

    logic [CW-1:0] wcol;
    logic          wrow;
    logic          wbank;
    logic          pend;
    logic          pend_bank;
    logic          pend_last;
    logic          pend_nx;

    logic          rd_bank;
    logic          rd_last;
    logic [KW-1:0] k;
    logic [1:0]    e;

    logic          row_end;
    logic          pair_done;
    logic          frame_err;
    logic          wr_en;
    logic          emit;
    logic          consume;
    logic          final_el;
    logic          cur_bank;
    logic          cur_last;
    logic [CW-1:0] rd_col;

    assign row_end   = (wcol == COL_LAST);
    assign pair_done = in_valid_i && wrow && row_end;
    // A last flag anywhere but the end of an odd row aborts the partial pair.
    assign frame_err = in_valid_i && in_last_i && !(wrow && row_end);
    assign wr_en     = in_valid_i && !frame_err;

    assign final_el  = (k == K_LAST) && (e == 2'd3);
    assign rd_col    = CW'({k, e[0]});
    assign pend_nx   = (pend && !consume) || (pair_done && !pend);

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wbank][wrow][wcol] <= in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wcol      <= '0;
            wrow      <= 1'b0;
            wbank     <= 1'b0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
            pend_last <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            pend <= pend_nx;
            if (frame_err) begin
                err_o <= 1'b1;
                wcol  <= '0;
                wrow  <= 1'b0;
            end else if (in_valid_i) begin
                if (row_end) begin
                    wcol <= '0;
                    wrow <= ~wrow;
                end else begin
                    wcol <= wcol + 1'b1;
                end
                if (pair_done) begin
                    if (pend) begin
                        err_o <= 1'b1;
                    end else begin
                        pend_bank <= wbank;
                        pend_last <= in_last_i;
                        wbank     <= ~wbank;
                    end
                end
            end
        end
    end

    // The IDLE->DRAIN edge already emits a1, straight from the pending bank.
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        consume  = 1'b0;
        cur_bank = rd_bank;
        cur_last = rd_last;
        case (state)
            IDLE: begin
                if (pend) begin
                    emit     = 1'b1;
                    consume  = 1'b1;
                    cur_bank = pend_bank;
                    cur_last = pend_last;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                emit = 1'b1;
                if (final_el) begin
                    if (pend) begin
                        consume = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            k            <= '0;
            e            <= 2'd0;
            rd_bank      <= 1'b0;
            rd_last      <= 1'b0;
            act_valid_o  <= 1'b0;
            act_last_o   <= 1'b0;
            act_result_o <= '0;
            busy_o       <= 1'b0;
        end else begin
            state       <= state_nx;
            act_valid_o <= emit;
            act_last_o  <= emit && final_el && cur_last;
            busy_o      <= (state_nx != IDLE) || pend_nx;
            if (emit) begin
                act_result_o <= mem[cur_bank][e[1]][rd_col];
                if (final_el) begin
                    k <= '0;
                    e <= 2'd0;
                end else begin
                    e <= e + 2'd1;
                    if (e == 2'd3) begin
                        k <= k + 1'b1;
                    end
                end
            end
            if (consume) begin
                rd_bank <= pend_bank;
                rd_last <= pend_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_window_feeder.sv
`default_nettype none
// tb_pool_window_feeder: scoreboard bench driving MAP_WIDTH=4 and MAP_WIDTH=28 instances.
module tb_pool_window_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       v4 = 1'b0, l4 = 1'b0, av4, al4, busy4, err4;
    logic [7:0] d4 = 8'd0, ar4;
    logic       v28 = 1'b0, l28 = 1'b0, av28, al28, busy28, err28;
    logic [7:0] d28 = 8'd0, ar28;

    pool_window_feeder #(.DATA_WIDTH(8), .MAP_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid_i(v4), .in_last_i(l4), .in_data_i(d4),
        .act_valid_o(av4), .act_last_o(al4), .act_result_o(ar4), .busy_o(busy4), .err_o(err4)
    );

    pool_window_feeder #(.DATA_WIDTH(8), .MAP_WIDTH(28)) dut28 (
        .clk(clk), .rst(rst), .in_valid_i(v28), .in_last_i(l28), .in_data_i(d28),
        .act_valid_o(av28), .act_last_o(al28), .act_result_o(ar28), .busy_o(busy28), .err_o(err28)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } smp_t;

    smp_t       exp_q[$];
    smp_t       got_q[$];
    int         got_cyc[$];
    int         pair_cyc[$];
    logic [7:0] pbuf[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_bad = 0;

    always @(posedge clk) cyc++;

    task automatic idle_in();
        v4 = 1'b0; l4 = 1'b0; v28 = 1'b0; l28 = 1'b0;
    endtask

    // Drives pixels and pushes the window-order expectations of every completed pair.
    task automatic send(input int m, input logic [7:0] px[$], input int last_idx, input bit gaps);
        for (int i = 0; i < px.size(); i++) begin
            @(posedge clk); #1;
            if (m == 4) begin v4 = 1'b1; l4 = (i == last_idx); d4 = px[i]; end
            else begin v28 = 1'b1; l28 = (i == last_idx); d28 = px[i]; end
            if ((i == last_idx) && (pbuf.size() != 2 * m - 1)) begin
                pbuf.delete();
            end else begin
                pbuf.push_back(px[i]);
                if (pbuf.size() == 2 * m) begin
                    pair_cyc.push_back(cyc + 1);
                    for (int k = 0; k < m / 2; k++) begin
                        for (int e = 0; e < 4; e++) begin
                            smp_t s;
                            s.d = pbuf[(e / 2) * m + 2 * k + (e % 2)];
                            s.l = (i == last_idx) && (k == m / 2 - 1) && (e == 3);
                            exp_q.push_back(s);
                        end
                    end
                    pbuf.delete();
                end
            end
            if (gaps) begin
                @(posedge clk); #1;
                idle_in();
            end
        end
        @(posedge clk); #1;
        idle_in();
    endtask

    // Collects every valid output sample for a fixed number of cycles.
    task automatic capture(input int m, input int budget);
        smp_t s;
        logic vld, bsy;
        got_q.delete();
        got_cyc.delete();
        busy_bad = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m == 4) begin vld = av4; bsy = busy4; s.d = ar4; s.l = al4; end
            else begin vld = av28; bsy = busy28; s.d = ar28; s.l = al28; end
            if (vld) begin
                got_q.push_back(s);
                got_cyc.push_back(cyc);
                if (!bsy && !s.l) busy_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({av4, al4, ar4, busy4, err4} !== 12'h000) begin
            errors++;
            $display("FAIL reset_w4: got %b, expected all zero", {av4, al4, ar4, busy4, err4});
        end
        checks++;
        if ({av28, al28, ar28, busy28, err28} !== 12'h000) begin
            errors++;
            $display("FAIL reset_w28: got %b, expected all zero", {av28, al28, ar28, busy28, err28});
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single_pair();
        logic [7:0] px[$];
        logic [7:0] order[8] = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd2, 8'd3, 8'd6, 8'd7};
        int n;
        bit gap = 0;
        pair_cyc.delete();
        for (int i = 0; i < 8; i++) px.push_back(8'(i));
        fork
            send(4, px, 7, 1'b0);
            capture(4, 30);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL single_pair count: got %0d, expected %0d", got_q.size(), n);
        end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            smp_t x;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x || got_q[i].d !== order[i]) begin
                errors++;
                $display("FAIL single_pair sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                         i, got_q[i].d, got_q[i].l, order[i], x.l);
            end
            if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gap = 1;
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] != pair_cyc[0] + 1) begin
            errors++;
            $display("FAIL single_pair latency: got cycle %0d, expected %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, pair_cyc[0] + 1);
        end
        checks++;
        if (gap || busy4 !== 1'b0 || err4 !== 1'b0) begin
            errors++;
            $display("FAIL single_pair burst/status: gap=%0d busy=%b err=%b, expected 0 0 0", gap, busy4, err4);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] px[$];
        int n;
        bit gap = 0;
        for (int i = 0; i < 16; i++) px.push_back(8'(i));
        fork
            send(4, px, 15, 1'b0);
            capture(4, 45);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n || n != 16) begin
            errors++;
            $display("FAIL back_to_back count: got %0d, expected 16", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            smp_t x;
            if (exp_q.size() == 0) break;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x) begin
                errors++;
                $display("FAIL back_to_back sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                         i, got_q[i].d, got_q[i].l, x.d, x.l);
            end
            if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gap = 1;
        end
        checks++;
        if (gap) begin
            errors++;
            $display("FAIL back_to_back continuity: got a bubble, expected 16 consecutive samples");
        end
        exp_q.delete();
    endtask

    task automatic test_gaps();
        logic [7:0] px[$];
        int n;
        bit gap = 0;
        pair_cyc.delete();
        for (int i = 0; i < 8; i++) px.push_back(8'(20 + i));
        fork
            send(4, px, 7, 1'b1);
            capture(4, 40);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL gaps count: got %0d, expected %0d", got_q.size(), n);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            smp_t x;
            if (exp_q.size() == 0) break;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x) begin
                errors++;
                $display("FAIL gaps sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                         i, got_q[i].d, got_q[i].l, x.d, x.l);
            end
            if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gap = 1;
        end
        checks++;
        if (gap || got_cyc.size() == 0 || got_cyc[0] != pair_cyc[0] + 1) begin
            errors++;
            $display("FAIL gaps timing: gap=%0d first=%0d, expected gap=0 first=%0d",
                     gap, (got_cyc.size() > 0) ? got_cyc[0] : -1, pair_cyc[0] + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_frame_error();
        logic [7:0] px[$];
        int n;
        for (int i = 0; i < 6; i++) px.push_back(8'(40 + i));
        fork
            send(4, px, 5, 1'b0);
            capture(4, 25);
        join
        checks++;
        if (got_q.size() != 0 || err4 !== 1'b1) begin
            errors++;
            $display("FAIL frame_error abort: got %0d samples err=%b, expected 0 samples err=1", got_q.size(), err4);
        end
        px.delete();
        for (int i = 0; i < 8; i++) px.push_back(8'(100 + i));
        fork
            send(4, px, 7, 1'b0);
            capture(4, 30);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n || n != 8) begin
            errors++;
            $display("FAIL frame_error recover count: got %0d, expected 8", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            smp_t x;
            if (exp_q.size() == 0) break;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x) begin
                errors++;
                $display("FAIL frame_error recover sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                         i, got_q[i].d, got_q[i].l, x.d, x.l);
            end
        end
        checks++;
        if (err4 !== 1'b1) begin
            errors++;
            $display("FAIL frame_error sticky: got err=%b, expected 1", err4);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] px[$];
        int seen = 0;
        int n;
        for (int i = 0; i < 8; i++) px.push_back(8'(50 + i));
        send(4, px, 7, 1'b0);
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            if (av4) seen++;
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL reset_mid_drain reach: got %0d samples, expected 3", seen);
        end
        rst = 1'b0;
        v4 = 1'b1; l4 = 1'b1; d4 = 8'd99;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        checks++;
        if ({av4, al4, ar4, busy4, err4} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_drain outputs: got %b, expected all zero", {av4, al4, ar4, busy4, err4});
        end
        exp_q.delete();
        pbuf.delete();
        px.delete();
        for (int i = 0; i < 8; i++) px.push_back(8'(60 + i));
        fork
            send(4, px, 7, 1'b0);
            capture(4, 30);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n || n != 8) begin
            errors++;
            $display("FAIL reset_mid_drain after count: got %0d, expected 8", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            smp_t x;
            if (exp_q.size() == 0) break;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x) begin
                errors++;
                $display("FAIL reset_mid_drain after sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                         i, got_q[i].d, got_q[i].l, x.d, x.l);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random_frame();
        logic [7:0] px[$];
        int n;
        int bad = 0;
        for (int i = 0; i < 28 * 28; i++) px.push_back(8'($urandom_range(0, 255)));
        fork
            send(28, px, 28 * 28 - 1, 1'b0);
            capture(28, 900);
        join
        n = exp_q.size();
        checks++;
        if (got_q.size() != n || n != 784) begin
            errors++;
            $display("FAIL random_frame count: got %0d, expected 784", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            smp_t x;
            if (exp_q.size() == 0) break;
            x = exp_q.pop_front();
            checks++;
            if (got_q[i] !== x) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL random_frame sample %0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                             i, got_q[i].d, got_q[i].l, x.d, x.l);
            end
        end
        checks++;
        if (busy_bad != 0 || busy28 !== 1'b0 || err28 !== 1'b0) begin
            errors++;
            $display("FAIL random_frame busy/err: busy-low samples=%0d busy=%b err=%b, expected 0 0 0",
                     busy_bad, busy28, err28);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_gaps();
        test_frame_error();
        test_reset_mid_drain();
        test_random_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pool_window_feeder.md
# pool_window_feeder

Sits between the activation unit and the 2x2 max-pooling unit, and drives the pooling unit's `act_*` input stream. It accepts a row-major activation feature map, one pixel per cycle with gaps allowed. It buffers two-row pairs in a ping-pong line buffer and re-emits each pair in 2x2 window order (a1, a2, a3, a4 per window) as a gap-free burst. The pooling unit can then take four consecutive valid samples per window without row storage of its own.

## Interface
- `DATA_WIDTH`, default 8: pixel width in bits.
- `MAP_WIDTH`, default 28: pixels per feature-map row. Must be even and ≥ 2.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `in_valid_i` input, 1 bit: `in_data_i` is valid this cycle.
- `in_last_i` input, 1 bit: qualified by `in_valid_i`; marks the final pixel of the frame.
- `in_data_i` input, `DATA_WIDTH` bits: activation pixel, row-major order.
- `act_valid_o` output, 1 bit: `act_result_o` is valid. No backpressure exists.
- `act_last_o` output, 1 bit: final sample of the frame (a4 of the last window).
- `act_result_o` output, `DATA_WIDTH` bits: pixel in window order.
- `busy_o` output, 1 bit: a drain is in progress or a completed pair is pending.
- `err_o` output, 1 bit: sticky framing error, cleared only by reset.

## Operation
- Storage is 2 banks × 2 rows × `MAP_WIDTH` entries.
- Write side:
  - Column counter `wcol` (0..`MAP_WIDTH`-1), row-parity bit `wrow`, bank bit `wbank`.
  - Each accepted pixel is written to [wbank][wrow][wcol], then `wcol` increments.
  - At `wcol`=`MAP_WIDTH`-1: `wcol`←0 and `wrow` toggles.
  - When `wrow`=1 and `wcol`=`MAP_WIDTH`-1, the pair is complete: set `pend`, record its bank, record `pend_last`=`in_last_i`, and toggle `wbank`.
- Read-side FSM:
  - IDLE → DRAIN when `pend`=1. This consumes `pend` and latches the bank and last flag.
  - DRAIN: window counter `k` (0..`MAP_WIDTH`/2-1) and element index `e` (0..3).
  - Element e emits: e0=[row0][2k], e1=[row0][2k+1], e2=[row1][2k], e3=[row1][2k+1].
  - A drain is exactly 2·`MAP_WIDTH` consecutive valid cycles.
  - At k=`MAP_WIDTH`/2-1, e=3: go to DRAIN again if `pend`=1 (no bubble), else go to IDLE.
- `act_last_o`=1 only on the final sample of a drain whose pair carried `in_last_i`.
- Frame end: correct `in_last_i` falls on the final pixel of an odd row. Pointers then return to `wcol`=0, `wrow`=0. `wbank` toggles as for any pair.
- Framing error: `in_last_i` at any other position (mid-row, or end of an even row).
  - `err_o`←1 (sticky).
  - Partial pair is discarded with no output for it; that last pixel is not buffered.
  - `wcol`, `wrow` ← 0; `wbank` unchanged.
- Overrun guard: a pair completing while `pend`=1 is dropped (write toggles nothing) and sets `err_o`. This is unreachable at ≤1 pixel/cycle.
- Pixel values pass through unmodified. There is no arithmetic.

## Timing
- Reset values: `act_valid_o`=0, `act_last_o`=0, `act_result_o`=0, `busy_o`=0, `err_o`=0. FSM=IDLE, all pointers 0, `pend`=0. Buffer contents are not cleared.
- Outputs are registered. The pair completes at edge t; the first window sample (a1) is valid in cycle t+1.
- `act_result_o` holds its last value when `act_valid_o`=0. `act_last_o` is 0 whenever `act_valid_o`=0.
- Back-to-back input at 1 pixel/cycle gives a continuous output stream after the first pair's 2·`MAP_WIDTH`-cycle fill latency.
- A write into bank b while bank !b drains is legal. Same-cycle write and read never target the same bank.
- `busy_o` = (FSM≠IDLE) | `pend`, registered with the FSM.
- Reset asserted mid-drain:
  - `act_valid_o` is 0 in the cycle after the reset edge.
  - All in-flight data is lost.
  - Pixels presented during reset are ignored.

## Test plan
- `MAP_WIDTH`=4, rows [0,1,2,3],[4,5,6,7], `in_last_i` on 7, continuous → outputs 0,1,4,5,2,3,6,7 starting one cycle after 7 is accepted; `act_last_o` only with 7.
- `MAP_WIDTH`=4, 4 rows of ramp 0..15, continuous, last on 15 → 0,1,4,5,2,3,6,7 then 8,9,12,13,10,11,14,15 with no gap between bursts; `act_last_o` only on 15.
- Same as the first scenario with `in_valid_i` toggling 1,0,1,0 → identical output order; burst is still 8 consecutive valid cycles.
- `in_last_i` on pixel index 5 (row 1, col 1) → no output; `err_o`=1 and stays 1. A following clean 8-pixel pair still outputs correctly.
- Reset pulsed during the 3rd drain sample → `act_valid_o`=0 next cycle, all outputs 0. A new pair after reset drains from bank 0 correctly.
- `MAP_WIDTH`=28 random frame of 28×28 → scoreboard window order matches the reference model. `busy_o` is low only between frames.
